controlador_puertas_n: RTL
==========================

# controlador_puertas_n

Clocked, parametrised elevator door controller for N floors. It sits between the floor-request logic and the door motor driver. It opens the doors when the cabin is stopped at a requested floor or the open button is pressed, times the opening, dwell and closing phases with internal counters, and reopens on obstruction. After a configurable number of reopenings it forces a close and raises an obstruction alarm.

## Interface
Parameters:
- N_PISOS, 4: number of floors (≥2).
- W_PISO, 2: floor index width; must satisfy 2^W_PISO ≥ N_PISOS.
- T_APERTURA, 8: cycles needed to fully open (≥1); also used for closing.
- T_ABIERTA, 50: dwell cycles with doors open (≥1).
- MAX_REAPERTURAS, 3: reopenings per open cycle before forced close (≥1).

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst_n, input, 1: reset. One clock; reset is asynchronous and active-low.
- piso, input, W_PISO: current cabin floor.
- en_movimiento, input, 1: the cabin is moving.
- solicitud_piso, input, N_PISOS: pending requests (cabin and hall merged), one bit per floor.
- boton_abrir, input, 1: open button, level.
- boton_cerrar, input, 1: close button, level.
- sensor, input, 1: obstruction between the doors.
- puertas, output, 2: door state. 00 = closed, 01 = open, 10 = opening, 11 = closing.
- salida_puertas, output, 2: motor command. 01 = open, 10 = close, 00 = none.
- trabajando, output, 1: high whenever the door state is not closed.
- aviso, output, N_PISOS: one-hot chime pulse, one cycle wide.
- atendido, output, N_PISOS: one-hot request-served pulse, one cycle wide.
- alarma_obstruccion, output, 1: forced-close (nudge) mode is active.

## Operation
- Four-state FSM: CERRADA, ABRIENDO, ABIERTA, CERRANDO. The state register drives `puertas` directly using the encoding above.
- A down-counter `cnt` is sized for max(T_APERTURA, T_ABIERTA). A reopen counter `nre` is sized for MAX_REAPERTURAS.
- `hit` = !en_movimiento && piso < N_PISOS && solicitud_piso[piso].
- CERRADA:
  - On `hit` or (boton_abrir && !en_movimiento && piso < N_PISOS): go to ABRIENDO and load cnt = T_APERTURA-1.
  - If `hit`, pulse aviso[piso] and atendido[piso] on the same transition.
  - Otherwise stay in CERRADA.
- ABRIENDO:
  - Decrement cnt. When cnt == 0, go to ABIERTA and load cnt = T_ABIERTA-1.
  - Buttons and sensor are ignored.
- ABIERTA, with priority in this order:
  1. sensor or boton_abrir: reload cnt = T_ABIERTA-1.
  2. boton_cerrar: go to CERRANDO immediately, loading cnt = T_APERTURA-1.
  3. cnt == 0: go to CERRANDO with the same load.
  4. Otherwise decrement cnt.
  - A `hit` while in ABIERTA pulses atendido[piso] (not aviso) and reloads the dwell counter.
- CERRANDO:
  - If (sensor or boton_abrir) and alarma_obstruccion == 0: go to ABRIENDO, load cnt = T_APERTURA-1, and increment nre.
  - If the incremented nre equals MAX_REAPERTURAS, set alarma_obstruccion on the same edge.
  - While alarma_obstruccion == 1, sensor and boton_abrir are ignored.
  - When cnt == 0: go to CERRADA and clear nre and alarma_obstruccion.
- salida_puertas: 01 in ABRIENDO, 10 in CERRANDO, 00 otherwise.
- en_movimiento is only consulted in CERRADA. It is ignored in every other state; the motion controller must hold the cabin while trabajando is high.
- If piso ≥ N_PISOS, no opening is ever initiated.

## Timing
- Reset values: puertas = 00, salida_puertas = 00, trabajando = 0, aviso = 0, atendido = 0, alarma_obstruccion = 0, cnt = 0, nre = 0.
- All outputs are registered or decoded from registers only. No combinational input-to-output path.
- Request latency:
  - A `hit` sampled at edge k gives puertas = 10 and an aviso pulse after edge k.
  - The pulse deasserts after edge k+1.
- Phase durations:
  - Opening lasts exactly T_APERTURA cycles in ABRIENDO.
  - Dwell lasts T_ABIERTA cycles without retriggers.
  - Closing lasts T_APERTURA cycles.
- Button priority in ABIERTA: boton_abrir and boton_cerrar asserted together → abrir wins. sensor together with boton_cerrar → sensor wins.
- A reopen from CERRANDO always restarts the full T_APERTURA count.
- Asserting rst_n low mid-operation returns to CERRADA immediately and clears nre and the alarm. The door motor command drops to 00 asynchronously.

## Test plan
- Request at floor 2 (N_PISOS = 4, T_APERTURA = 8, T_ABIERTA = 50), cabin stopped:
  - aviso = 0100 and atendido = 0100 for 1 cycle.
  - puertas sequence: 10 for 8 cycles, 01 for 50 cycles, 11 for 8 cycles, then 00.
- Request at floor 1 with en_movimiento = 1: puertas stays 00 and no pulses occur. Dropping en_movimiento starts opening on the next edge.
- boton_cerrar pulsed on the 5th cycle of ABIERTA: puertas = 11 on the next cycle. With boton_abrir asserted in the same cycle, puertas stays 01 and the dwell restarts.
- sensor asserted during each of 3 consecutive closings (MAX_REAPERTURAS = 3):
  - Three reopenings occur, and alarma_obstruccion = 1 after the third.
  - The 4th close completes despite sensor = 1, then the alarm clears at puertas = 00.
- piso = 5 with N_PISOS = 4 and boton_abrir = 1: no state change.
- rst_n pulled low mid-opening: all outputs return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/controlador_puertas_n.sv
// rtl/controlador_puertas_n.sv - elevator door controller: open/dwell/close timing, reopen on obstruction, nudge alarm
module controlador_puertas_n #(
    parameter int N_PISOS         = 4,
    parameter int W_PISO          = 2,
    parameter int T_APERTURA      = 8,
    parameter int T_ABIERTA       = 50,
    parameter int MAX_REAPERTURAS = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [W_PISO-1:0]  piso,
    input  logic               en_movimiento,
    input  logic [N_PISOS-1:0] solicitud_piso,
    input  logic               boton_abrir,
    input  logic               boton_cerrar,
    input  logic               sensor,
    output logic [1:0]         puertas,
    output logic [1:0]         salida_puertas,
    output logic               trabajando,
    output logic [N_PISOS-1:0] aviso,
    output logic [N_PISOS-1:0] atendido,
    output logic               alarma_obstruccion
);

    // State encoding doubles as the puertas output code.
    typedef enum logic [1:0] {
        CERRADA  = 2'b00,
        ABIERTA  = 2'b01,
        ABRIENDO = 2'b10,
        CERRANDO = 2'b11
    } estado_t;

    localparam int T_MAX = (T_APERTURA > T_ABIERTA) ? T_APERTURA : T_ABIERTA;
    localparam int CW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;
    localparam int NW    = $clog2(MAX_REAPERTURAS + 1);

    localparam logic [CW-1:0] CARGA_AP = CW'(T_APERTURA - 1);
    localparam logic [CW-1:0] CARGA_AB = CW'(T_ABIERTA - 1);
    localparam logic [NW-1:0] NRE_MAX  = NW'(MAX_REAPERTURAS);

    estado_t            estado;
    logic [CW-1:0]      cnt;
    logic [NW-1:0]      nre;
    logic [NW-1:0]      nre_inc;
    logic [N_PISOS-1:0] piso_oh;
    logic               piso_valido;
    logic               piso_sol;
    logic               hit;
    logic               abrir_pedido;

    // One-hot decode of the cabin floor; floors at or beyond N_PISOS decode to zero,
    // so an out-of-range floor can never request or initiate an opening.
    always_comb begin
        piso_oh = '0;
        for (int i = 0; i < N_PISOS; i++) begin
            if (piso == W_PISO'(i)) begin
                piso_oh[i] = 1'b1;
            end
        end
    end

    assign piso_valido  = |piso_oh;
    assign piso_sol     = |(piso_oh & solicitud_piso);
    assign hit          = !en_movimiento && piso_sol;
    assign abrir_pedido = hit || (boton_abrir && !en_movimiento && piso_valido);
    assign nre_inc      = nre + NW'(1);

    // Door sequencing FSM with phase counter, reopen counter and one-cycle pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado             <= CERRADA;
            cnt                <= '0;
            nre                <= '0;
            alarma_obstruccion <= 1'b0;
            aviso              <= '0;
            atendido           <= '0;
        end else begin
            aviso    <= '0;
            atendido <= '0;
            case (estado)
                CERRADA: begin
                    if (abrir_pedido) begin
                        estado <= ABRIENDO;
                        cnt    <= CARGA_AP;
                        if (hit) begin
                            aviso    <= piso_oh;
                            atendido <= piso_oh;
                        end
                    end
                end
                ABRIENDO: begin
                    if (cnt == '0) begin
                        estado <= ABIERTA;
                        cnt    <= CARGA_AB;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ABIERTA: begin
                    // The cabin is held while doors are open, so motion is not checked here.
                    if (piso_sol) begin
                        atendido <= piso_oh;
                    end
                    if (sensor || boton_abrir || piso_sol) begin
                        cnt <= CARGA_AB;
                    end else if (boton_cerrar || cnt == '0) begin
                        estado <= CERRANDO;
                        cnt    <= CARGA_AP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                CERRANDO: begin
                    if ((sensor || boton_abrir) && !alarma_obstruccion) begin
                        estado <= ABRIENDO;
                        cnt    <= CARGA_AP;
                        nre    <= nre_inc;
                        if (nre_inc == NRE_MAX) begin
                            alarma_obstruccion <= 1'b1;
                        end
                    end else if (cnt == '0) begin
                        estado             <= CERRADA;
                        nre                <= '0;
                        alarma_obstruccion <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    estado <= CERRADA;
                end
            endcase
        end
    end

    assign puertas        = estado;
    assign trabajando     = (estado != CERRADA);
    assign salida_puertas = (estado == ABRIENDO) ? 2'b01 :
                            (estado == CERRANDO) ? 2'b10 : 2'b00;

endmodule
